spike_accum_mac: RTL and testbench

//  Multi-beat synaptic accumulator: each beat takes LANES spike bits with one signed weight
//  per lane, sums the weights of spiking lanes, and adds them into a saturating accumulator.
//  A packet of 1..MAX_BEATS beats, terminated by in_last, yields one membrane-current

---
 rtl/spike_accum_mac.sv | 130 +++++++++++++
 tb/tb_spike_accum_mac.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spike_accum_mac.sv
// Multi-beat synaptic accumulator: sums the weights of spiking lanes per beat into a
// saturating accumulator and presents one result per packet over a valid/ready handshake.
module spike_accum_mac #(
  parameter int LANES     = 4,
  parameter int W_WIDTH   = 32,
  parameter int ACC_WIDTH = 32,
  parameter int MAX_BEATS = 16,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0]           spike_in,
  input  logic [LANES*W_WIDTH-1:0]   weight_in,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       sum_out,
  output logic                       sat_out,
  output logic [CW-1:0]              beats_out,
  output logic                       overrun
);

  // Handshakes: a beat moves when in_valid & in_ready at a rising edge; a result moves when
  // out_valid & out_ready at a rising edge. Neither side may depend combinationally on the other.

  localparam int PW = W_WIDTH + $clog2(LANES) + 1;
  localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        sat;
  logic [CW-1:0]               cnt;

  logic signed [PW-1:0]        partial;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [SW-1:0]        s_full;
  logic signed [SW-1:0]        acc_max;
  logic signed [SW-1:0]        acc_min;
  logic                        clamp;
  logic                        sat_next;
  logic [CW-1:0]               cnt_next;
  logic                        hit_max;
  logic                        close_pkt;
  logic                        accept;

  assign acc_max = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  assign acc_min = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  always_comb begin
    partial = '0;
    for (int i = 0; i < LANES; i++) begin
      if (spike_in[i]) partial = partial + PW'($signed(weight_in[i*W_WIDTH +: W_WIDTH]));
    end
  end

  // The first beat of a packet starts from zero, so IDLE needs no separate clear cycle.
  always_comb begin
    acc_base = (state == IDLE) ? '0 : acc;
    s_full   = SW'(acc_base) + SW'(partial);
    clamp    = 1'b0;
    acc_next = s_full[ACC_WIDTH-1:0];
    if (s_full > acc_max) begin
      acc_next = acc_max[ACC_WIDTH-1:0];
      clamp    = 1'b1;
    end else if (s_full < acc_min) begin
      acc_next = acc_min[ACC_WIDTH-1:0];
      clamp    = 1'b1;
    end
    sat_next  = ((state == IDLE) ? 1'b0 : sat) | clamp;
    cnt_next  = (state == IDLE) ? CW'(1) : cnt + CW'(1);
    hit_max   = (cnt_next == CW'(MAX_BEATS));
    close_pkt = in_last | hit_max;
    accept    = in_valid & in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      sat       <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum_out   <= '0;
      sat_out   <= 1'b0;
      beats_out <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            acc <= acc_next;
            sat <= sat_next;
            cnt <= cnt_next;
            if (close_pkt) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              sum_out   <= acc_next;
              sat_out   <= sat_next;
              beats_out <= cnt_next;
              overrun   <= ~in_last;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            sat       <= 1'b0;
            cnt       <= '0;
            overrun   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_accum_mac.sv
// Directed bench for spike_accum_mac: stimulus pushes expected results into a queue and a
// separate monitor pops and compares them at each result handshake.
module tb_spike_accum_mac;

  localparam int LANES = 4;
  localparam int W     = 32;
  localparam int AW    = 32;
  localparam int MB    = 16;
  localparam int CW    = $clog2(MB + 1);
  localparam int EW    = AW + CW + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [LANES-1:0] spike_in = '0;
  logic [LANES*W-1:0] weight_in = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [AW-1:0]    sum_out;
  logic             sat_out;
  logic [CW-1:0]    beats_out;
  logic             overrun;

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_last = 0;
  int hs_prev = 0;

  spike_accum_mac #(.LANES(LANES), .W_WIDTH(W), .ACC_WIDTH(AW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .spike_in(spike_in), .weight_in(weight_in), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
    .sat_out(sat_out), .beats_out(beats_out), .overrun(overrun)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [EW-1:0] mk(input logic [AW-1:0] s, input logic st,
                                       input logic [CW-1:0] b, input logic ov);
    return {s, st, b, ov};
  endfunction

  function automatic logic [LANES*W-1:0] w4(input int a3, input int a2, input int a1, input int a0);
    return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // driver: present one beat at a negedge, wait for in_ready, complete at the next posedge
  task automatic send_beat(input logic [LANES-1:0] sp, input logic [LANES*W-1:0] w, input logic last);
    int t = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    spike_in  = sp;
    weight_in = w;
    in_last   = last;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_timeout: in_ready=0 for 100 cycles, want 1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // monitor / scoreboard: compare while out_valid, pop on handshake
  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got sum=%0h beats=%0d ov=%0b, want no result",
                 sum_out, beats_out, overrun);
      end else begin
        chk("result", 64'({sum_out, sat_out, beats_out, overrun}), 64'(exp_q[0]));
        chk("in_ready_in_hold", 64'(in_ready), 64'd0);
        if (out_ready) begin
          void'(exp_q.pop_front());
          hs_prev = hs_last;
          hs_last = cyc;
        end
      end
    end
  end

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({in_ready, out_valid, sum_out, sat_out, beats_out, overrun}), 64'd0);
    rst_n = 1'b1;

    // single beat, lanes 3 and 1 spike
    exp_q.push_back(mk(32'd47, 1'b0, CW'(1), 1'b0));
    send_beat(4'b1010, w4(40, -3, 7, 100), 1'b1);
    chk("t1_latency", 64'(out_valid), 64'd1);
    drain("t1_drain");

    // three beats with result held back for 4 cycles
    @(negedge clk);
    out_ready = 1'b0;
    exp_q.push_back(mk(32'd25, 1'b0, CW'(3), 1'b0));
    send_beat(4'b1111, w4(5, 5, 5, 5), 1'b0);
    send_beat(4'b0000, w4(5, 5, 5, 5), 1'b0);
    send_beat(4'b0001, w4(5, 5, 5, 5), 1'b1);
    repeat (4) @(negedge clk);
    chk("t2_held_valid", 64'(out_valid), 64'd1);
    chk("t2_held_sum", 64'(sum_out), 64'd25);
    out_ready = 1'b1;
    drain("t2_drain");

    // positive and negative saturation
    exp_q.push_back(mk(32'h7FFF_FFFF, 1'b1, CW'(2), 1'b0));
    send_beat(4'b1111, {4{32'h3FFF_FFFF}}, 1'b0);
    send_beat(4'b1111, {4{32'h3FFF_FFFF}}, 1'b1);
    exp_q.push_back(mk(32'h8000_0000, 1'b1, CW'(2), 1'b0));
    send_beat(4'b1111, {4{32'hC000_0000}}, 1'b0);
    send_beat(4'b1111, {4{32'hC000_0000}}, 1'b1);
    drain("t3_drain");

    // overrun at MAX_BEATS; beat 17 stalls then opens a new packet
    exp_q.push_back(mk(32'd16, 1'b0, CW'(16), 1'b1));
    for (int i = 0; i < MB; i++) send_beat(4'b0001, w4(0, 0, 0, 1), 1'b0);
    exp_q.push_back(mk(32'd1, 1'b0, CW'(1), 1'b0));
    send_beat(4'b0001, w4(0, 0, 0, 1), 1'b1);
    drain("t4_drain");

    // reset mid-packet discards the partial packet
    send_beat(4'b0001, w4(0, 0, 0, 3), 1'b0);
    send_beat(4'b0001, w4(0, 0, 0, 3), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_rst_quiet", 64'({out_valid, in_ready}), 64'd0);
    rst_n = 1'b1;
    exp_q.push_back(mk(32'd9, 1'b0, CW'(1), 1'b0));
    send_beat(4'b0001, w4(0, 0, 0, 9), 1'b1);
    drain("t5_drain");

    // back-to-back packets with in_valid held across the handshake
    exp_q.push_back(mk(32'd5, 1'b0, CW'(1), 1'b0));
    send_beat(4'b0001, w4(0, 0, 0, 5), 1'b1);
    exp_q.push_back(mk(32'hFFFF_FFF8, 1'b0, CW'(1), 1'b0));
    send_beat(4'b0111, w4(100, -2, 5, -11), 1'b1);
    drain("t6_drain");
    chk("t6_gap", 64'(hs_last - hs_prev), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: run exceeded time limit, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
